// File: rtl/trng_bit_collector.sv
// Consumer side of the metastable entropy source: repetition-count health test,
// von Neumann debiasing and packing of debiased bits into WIDTH-bit words with a valid/ready output.
module trng_bit_collector #(
    parameter int WIDTH      = 8,
    parameter int RCT_CUTOFF = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             raw_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             health_fail,
    output logic             overflow
);

    localparam int          CW       = $clog2(WIDTH + 1);
    localparam logic [7:0]  CUTOFF   = 8'(RCT_CUTOFF);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    logic             phase;
    logic             first_bit;
    logic             prev_bit;
    logic             stall;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       rep_cnt;

    logic             deb_valid;
    logic [WIDTH-1:0] shifted;
    logic             xfer;
    logic             slot_free;
    logic [7:0]       rep_next;

    // A differing pair yields its first sample: 10 -> 1, 01 -> 0.
    assign deb_valid = en && phase && (first_bit != raw_bit);
    assign shifted   = {shreg[WIDTH-2:0], first_bit};
    assign xfer      = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        rep_next = rep_cnt;
        if (!en)
            rep_next = 8'd0;
        else if (rep_cnt == 8'd0 || raw_bit != prev_bit)
            rep_next = 8'd1;
        else if (rep_cnt < CUTOFF)
            rep_next = rep_cnt + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            phase       <= 1'b0;
            first_bit   <= 1'b0;
            prev_bit    <= 1'b0;
            stall       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= 8'd0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            health_fail <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rep_cnt <= rep_next;
            if (en)
                prev_bit <= raw_bit;
            if (rep_next == CUTOFF)
                health_fail <= 1'b1;

            if (!en) begin
                phase <= 1'b0;
            end else begin
                phase <= ~phase;
                if (!phase)
                    first_bit <= raw_bit;
            end

            if (xfer)
                out_valid <= 1'b0;

            if (stall) begin
                if (health_fail) begin
                    // The held word is no longer trustworthy once the source has failed.
                    stall   <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    if (xfer) begin
                        out_data  <= shreg;
                        out_valid <= 1'b1;
                        stall     <= 1'b0;
                        bit_cnt   <= '0;
                    end
                    if (deb_valid)
                        overflow <= 1'b1;
                end
            end else if (deb_valid && !health_fail) begin
                shreg <= shifted;
                if (bit_cnt == LAST_BIT) begin
                    if (slot_free) begin
                        out_data  <= shifted;
                        out_valid <= 1'b1;
                        bit_cnt   <= '0;
                    end else begin
                        stall   <= 1'b1;
                        bit_cnt <= FULL_CNT;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_bit_collector.sv
// Self-checking bench for trng_bit_collector: words expected from the stimulus are queued
// and compared against every accepted output transfer.
module tb_trng_bit_collector;

    localparam int WIDTH = 8;

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             raw_bit = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             health_fail;
    logic             overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    trng_bit_collector #(.WIDTH(WIDTH), .RCT_CUTOFF(32)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .overflow    (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transfers happen on the next rising edge; inputs only change just after rising edges.
    always @(negedge clk_in) begin
        if (!rst && out_valid && out_ready) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive(input logic b);
        raw_bit = b;
        en      = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit push);
        if (push)
            exp_q.push_back(w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            drive(w[i]);
            drive(~w[i]);
        end
    endtask

    task automatic scenario_basic();
        out_ready = 1'b1;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 15; i++)
            drive(1'(~i & 1));
        check("valid_before_last", 32'(out_valid), 32'd0);
        drive(1'b0);
        check("valid_latency", 32'(out_valid), 32'd1);
        check("data_ff", 32'(out_data), 32'hFF);
        send_word(8'h00, 1'b1);
        check("valid_w2", 32'(out_valid), 32'd1);
        check("data_00", 32'(out_data), 32'h00);
        idle(2);
        check("valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_health", 32'(health_fail), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Scenario 1: 10 x8 -> 0xFF, 01 x8 -> 0x00.
        scenario_basic();

        // Scenario 2: equal pairs are dropped.
        exp_q.push_back(8'hAA);
        for (int r = 0; r < 4; r++) begin
            drive(1'b1); drive(1'b0);
            drive(1'b0); drive(1'b0);
            drive(1'b0); drive(1'b1);
            drive(1'b1); drive(1'b1);
        end
        check("aa_data", 32'(out_data), 32'hAA);
        idle(2);
        check("aa_single", 32'(out_valid), 32'd0);

        // Scenario 3: backpressure, stall and overflow.
        out_ready = 1'b0;
        send_word(8'hC3, 1'b1);
        send_word(8'h5A, 1'b1);
        check("stall_data", 32'(out_data), 32'hC3);
        check("stall_ovf0", 32'(overflow), 32'd0);
        send_word(8'h96, 1'b0);
        check("stall_ovf1", 32'(overflow), 32'd1);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data_hold", 32'(out_data), 32'hC3);
        en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        check("b2b_valid", 32'(out_valid), 32'd1);
        @(posedge clk_in); #1;
        out_ready = 1'b0;
        check("b2b_done", 32'(out_valid), 32'd0);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Scenario 4: repetition-count trip at exactly 32 samples.
        out_ready = 1'b1;
        for (int i = 0; i < 31; i++)
            drive(1'b1);
        check("rct_31", 32'(health_fail), 32'd0);
        drive(1'b1);
        check("rct_32", 32'(health_fail), 32'd1);
        for (int i = 0; i < 16; i++)
            drive(1'(i & 1));
        check("rct_sticky", 32'(health_fail), 32'd1);
        check("rct_no_word", 32'(out_valid), 32'd0);

        // Scenario 5: orphan sample discarded by en drop; reset mid-word.
        do_reset();
        check("rst2_health", 32'(health_fail), 32'd0);
        drive(1'b1);
        idle(1);
        send_word(8'h35, 1'b1);
        check("orphan_data", 32'(out_data), 32'h35);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            drive(1'b0);
        end
        idle(2);
        do_reset();
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        send_word(8'h0F, 1'b1);
        check("fresh_data", 32'(out_data), 32'h0F);
        idle(2);

        // Scenario 6: reset clears sticky flags and collection resumes.
        out_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        for (int i = 0; i < 32; i++)
            drive(1'b1);
        check("pre_rst_health", 32'(health_fail), 32'd1);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        do_reset();
        check("post_rst_health", 32'(health_fail), 32'd0);
        check("post_rst_ovf", 32'(overflow), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        scenario_basic();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
